// File: rtl/rate_pkg.sv
// Shared rate-select codes, nominal periods and detector state encoding.
// Used by the clock-enable rate divider and by tick_rate_detector.
// Pure declarations and helper functions; no clocked logic.
package rate_pkg;

    // Divider select codes
    localparam logic [1:0] RATE_SEL_DIV2  = 2'b00;
    localparam logic [1:0] RATE_SEL_250HZ = 2'b01;
    localparam logic [1:0] RATE_SEL_100HZ = 2'b10;
    localparam logic [1:0] RATE_SEL_1HZ   = 2'b11;

    // Nominal edge-to-edge periods produced by the divider, in CLOCK_50 cycles
    localparam logic [31:0] RATE_PERIOD_DIV2  = 32'd2;
    localparam logic [31:0] RATE_PERIOD_250HZ = 32'd200001;
    localparam logic [31:0] RATE_PERIOD_100HZ = 32'd500001;
    localparam logic [31:0] RATE_PERIOD_1HZ   = 32'd50000001;

    // Detector state
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } rate_state_t;

    // Result of classifying one measured period
    typedef struct packed {
        logic       hit;
        logic [1:0] code;
    } rate_class_t;

    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // First nominal in code order 00,01,10,11 within tol wins; on no hit the
    // code field is don't-care and the caller keeps its previous code.
    function automatic rate_class_t classify(
        input logic [31:0] p,
        input logic [31:0] tol,
        input logic [31:0] n0,
        input logic [31:0] n1,
        input logic [31:0] n2,
        input logic [31:0] n3
    );
        rate_class_t r;
        r.hit  = 1'b1;
        r.code = RATE_SEL_DIV2;
        if (abs_diff(p, n0) <= tol) begin
            r.code = RATE_SEL_DIV2;
        end else if (abs_diff(p, n1) <= tol) begin
            r.code = RATE_SEL_250HZ;
        end else if (abs_diff(p, n2) <= tol) begin
            r.code = RATE_SEL_100HZ;
        end else if (abs_diff(p, n3) <= tol) begin
            r.code = RATE_SEL_1HZ;
        end else begin
            r.hit = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_edge_sync.sv
// Optional 2-flop synchroniser (TICK_SYNC_EN) plus rising-edge detector for tick_in.
// Latency: rise asserts in the cycle tick_in is first sampled high (+2 cycles with TICK_SYNC_EN).
// No backpressure: the tick stream is observed, never stalled.
module tick_edge_sync
    import rate_pkg::*;
(
    input  logic CLOCK_50,
    input  logic reset,
    input  logic tick_in,
    output logic rise
);

    logic tick_q;
    logic tick_q_d;

`ifdef TICK_SYNC_EN
    logic [1:0] sync_ff;

    // Two-stage synchroniser so tick_in may come from an unrelated clock domain
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], tick_in};
        end
    end

    assign tick_q = sync_ff[1];
`else
    assign tick_q = tick_in;
`endif

    // Delayed copy of the sampled tick for edge detection
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            tick_q_d <= 1'b0;
        end else begin
            tick_q_d <= tick_q;
        end
    end

    assign rise = tick_q & ~tick_q_d;

endmodule

// File: rtl/tick_rate_detector.sv
// Measures tick_in edge-to-edge period, classifies it to a rate code, locks on two matches.
// Latency: period/period_valid/rate_* update one cycle after the rising edge (+2 with TICK_SYNC_EN).
// No backpressure: results are single-cycle pulses/registers; consumer must sample them.
module tick_rate_detector
    import rate_pkg::*;
#(
    parameter int unsigned TOL     = 16,
    parameter int unsigned TIMEOUT = 60000000,
    // Nominal periods default to the divider outputs; overridable for scaled-down setups
    parameter logic [31:0] NOM_00  = RATE_PERIOD_DIV2,
    parameter logic [31:0] NOM_01  = RATE_PERIOD_250HZ,
    parameter logic [31:0] NOM_10  = RATE_PERIOD_100HZ,
    parameter logic [31:0] NOM_11  = RATE_PERIOD_1HZ
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        tick_in,
    output logic [31:0] period,
    output logic        period_valid,
    output logic [1:0]  rate_code,
    output logic        rate_match,
    output logic        locked,
    output logic        timeout
);

    localparam logic [31:0] TOL_W     = 32'(TOL);
    localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

    logic        rise;
    logic [31:0] cnt;
    logic        cnt_at_limit;
    rate_class_t cls;
    rate_state_t state;
    logic [1:0]  cand;
    logic        cand_valid;

    tick_edge_sync u_edge (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .tick_in  (tick_in),
        .rise     (rise)
    );

    // cnt holds the number of cycles since the last edge, so at an edge it is the period
    assign cnt_at_limit = (cnt >= TIMEOUT_W);
    assign cls          = classify(cnt, TOL_W, NOM_00, NOM_01, NOM_10, NOM_11);

    // Period counter: restarts at 1 on every edge, saturates at TIMEOUT
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= 32'd1;
        end else if (!cnt_at_limit) begin
            cnt <= cnt + 32'd1;
        end
    end

    // Lock FSM with registered result outputs; an edge always takes priority over timeout
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            period       <= '0;
            period_valid <= 1'b0;
            rate_code    <= 2'b00;
            rate_match   <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
            cand         <= 2'b00;
            cand_valid   <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            timeout      <= 1'b0;

            // Any edge outside IDLE closes a full period and publishes it
            if (rise && (state != IDLE)) begin
                period       <= cnt;
                period_valid <= 1'b1;
                rate_match   <= cls.hit;
                if (cls.hit) begin
                    rate_code <= cls.code;
                end
            end

            case (state)
                IDLE: begin
                    // First edge only opens a measurement window
                    if (rise) begin
                        state <= MEASURE;
                    end
                end

                MEASURE: begin
                    if (rise) begin
                        if (cls.hit && cand_valid && (cls.code == cand)) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else if (cls.hit) begin
                            cand       <= cls.code;
                            cand_valid <= 1'b1;
                        end else begin
                            cand_valid <= 1'b0;
                        end
                    end else if (cnt_at_limit) begin
                        state      <= IDLE;
                        locked     <= 1'b0;
                        cand_valid <= 1'b0;
                        timeout    <= 1'b1;
                    end
                end

                LOCKED: begin
                    if (rise) begin
                        // rate_code still holds the locked code here
                        if (!cls.hit || (cls.code != rate_code)) begin
                            state      <= MEASURE;
                            locked     <= 1'b0;
                            cand_valid <= cls.hit;
                            if (cls.hit) begin
                                cand <= cls.code;
                            end
                        end
                    end else if (cnt_at_limit) begin
                        state      <= IDLE;
                        locked     <= 1'b0;
                        cand_valid <= 1'b0;
                        timeout    <= 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    locked     <= 1'b0;
                    cand_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_rate_detector.sv
// Directed bench with an expected-result queue for tick_rate_detector.
// Runs with scaled nominal periods (2/201/501/901) and TIMEOUT=1000.
// Each reported period is popped from the queue and compared field by field.
module tb_tick_rate_detector;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic        tick_in  = 1'b0;
    logic [31:0] period;
    logic        period_valid;
    logic [1:0]  rate_code;
    logic        rate_match;
    logic        locked;
    logic        timeout;

    int checks = 0;
    int errors = 0;
    int tmo_seen = 0;

    typedef struct packed {
        logic [31:0] per;
        logic        match;
        logic [1:0]  code;
        logic        lk;
    } exp_t;

    exp_t exp_q[$];

    tick_rate_detector #(
        .TOL     (16),
        .TIMEOUT (1000),
        .NOM_00  (32'd2),
        .NOM_01  (32'd201),
        .NOM_10  (32'd501),
        .NOM_11  (32'd901)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .tick_in      (tick_in),
        .period       (period),
        .period_valid (period_valid),
        .rate_code    (rate_code),
        .rate_match   (rate_match),
        .locked       (locked),
        .timeout      (timeout)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Rising edge exactly gap cycles after the previous one; optionally expect a report
    task automatic edge_after(input int gap, input bit rep, input logic [31:0] e_per,
                              input logic e_match, input logic [1:0] e_code, input logic e_lk);
        exp_t e;
        tick_in = 1'b0;
        repeat (gap - 1) @(negedge CLOCK_50);
        tick_in = 1'b1;
        if (rep) begin
            e.per   = e_per;
            e.match = e_match;
            e.code  = e_code;
            e.lk    = e_lk;
            exp_q.push_back(e);
        end
        @(negedge CLOCK_50);
    endtask

    // Output monitor: pops one expectation per reported period, counts timeout pulses
    always @(negedge CLOCK_50) begin
        if (!reset) begin
            if (timeout) tmo_seen++;
            if (period_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_period_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("period",     period,            e.per);
                    check("rate_match", {31'd0, rate_match}, {31'd0, e.match});
                    check("rate_code",  {30'd0, rate_code},  {30'd0, e.code});
                    check("locked",     {31'd0, locked},     {31'd0, e.lk});
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_period"},  period, 32'd0);
        check({tag, "_pvalid"},  {31'd0, period_valid}, 32'd0);
        check({tag, "_code"},    {30'd0, rate_code}, 32'd0);
        check({tag, "_match"},   {31'd0, rate_match}, 32'd0);
        check({tag, "_locked"},  {31'd0, locked}, 32'd0);
        check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    endtask

    initial begin
        int tmo_before;

        // Reset state
        repeat (3) @(negedge CLOCK_50);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge CLOCK_50);

        // Period 2 (tick toggling every cycle): lock after third rise
        edge_after(2, 1'b0, 0, 0, 0, 0);
        edge_after(2, 1'b1, 32'd2, 1'b1, 2'b00, 1'b0);
        edge_after(2, 1'b1, 32'd2, 1'b1, 2'b00, 1'b1);
        edge_after(2, 1'b1, 32'd2, 1'b1, 2'b00, 1'b1);

        // Move to 01: first gap breaks lock, second relocks
        edge_after(201, 1'b1, 32'd201, 1'b1, 2'b01, 1'b0);
        edge_after(201, 1'b1, 32'd201, 1'b1, 2'b01, 1'b1);

        // Locked at 01, then 10 gaps
        edge_after(501, 1'b1, 32'd501, 1'b1, 2'b10, 1'b0);
        edge_after(501, 1'b1, 32'd501, 1'b1, 2'b10, 1'b1);

        // Unmatched period: no match, lock lost, code held
        edge_after(300, 1'b1, 32'd300, 1'b0, 2'b10, 1'b0);
        edge_after(300, 1'b1, 32'd300, 1'b0, 2'b10, 1'b0);

        // Tolerance boundaries around 501 and 201
        edge_after(501, 1'b1, 32'd501, 1'b1, 2'b10, 1'b0);
        edge_after(517, 1'b1, 32'd517, 1'b1, 2'b10, 1'b1);
        edge_after(518, 1'b1, 32'd518, 1'b0, 2'b10, 1'b0);
        edge_after(185, 1'b1, 32'd185, 1'b1, 2'b01, 1'b0);

        // Silence: exactly one timeout pulse, not repeated while idle
        tmo_before = tmo_seen;
        tick_in = 1'b0;
        repeat (1100) @(negedge CLOCK_50);
        check("timeout_once", tmo_seen - tmo_before, 32'd1);
        check("locked_after_timeout", {31'd0, locked}, 32'd0);
        repeat (500) @(negedge CLOCK_50);
        check("timeout_no_repeat", tmo_seen - tmo_before, 32'd1);

        // Rise on the final count cycle wins over timeout
        edge_after(2, 1'b0, 0, 0, 0, 0);
        tmo_before = tmo_seen;
        edge_after(1000, 1'b1, 32'd1000, 1'b0, 2'b01, 1'b0);
        repeat (3) @(negedge CLOCK_50);
        check("rise_beats_timeout", tmo_seen - tmo_before, 32'd0);

        // Held-high tick: no edges, ends in a single timeout
        tick_in = 1'b1;
        repeat (1100) @(negedge CLOCK_50);
        check("held_high_timeout", tmo_seen - tmo_before, 32'd1);

        // Relock at 00, then reset mid-period
        edge_after(2, 1'b0, 0, 0, 0, 0);
        edge_after(2, 1'b1, 32'd2, 1'b1, 2'b00, 1'b0);
        edge_after(2, 1'b1, 32'd2, 1'b1, 2'b00, 1'b1);
        tick_in = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);

        // Partial period discarded; two new periods relock
        edge_after(2, 1'b0, 0, 0, 0, 0);
        edge_after(2, 1'b1, 32'd2, 1'b1, 2'b00, 1'b0);
        edge_after(2, 1'b1, 32'd2, 1'b1, 2'b00, 1'b1);

        repeat (5) @(negedge CLOCK_50);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
